xm_uart_tx_arb: RTL and testbench

Four-port round-robin arbiter and sequencer in front of the `xm_uart_tx` transmitter. Requesters present a byte with a level request; the block chooses one and latches its byte and the baud selection. It then pulses `send_en` to the transmitter and holds `data_byte` stable for the whole frame. It waits for `tx_done`, then reports completion to the winning requester. A watchdog aborts a frame whose `tx_done` never arrives.

---
 rtl/xm_uart_tx_arb_if.sv | 46 ++++
 rtl/xm_uart_tx_arb.sv | 155 +++++++++++++++
 tb/tb_xm_uart_tx_arb.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xm_uart_tx_arb_if.sv
// ============================================================================
//  Module      : xm_uart_tx_arb_if
//  Description : Bundle of the requester-side and transmitter-side signals
//                of the xm_uart_tx_arb arbiter/sequencer.
//                  req       [3:0]  per-requester level request
//                  req_data  [31:0] packed request bytes, byte i = [8i+7:8i]
//                  baud_cfg  [2:0]  baud selection, sampled at grant
//                  tx_done          one-cycle completion pulse from the UART
//                  gnt       [3:0]  one-hot grant pulse
//                  done      [3:0]  one-hot completion pulse
//                  err              watchdog abort pulse
//                  busy             high whenever the arbiter is not idle
//                  send_en          one-cycle start pulse to the UART
//                  data_byte [7:0]  byte to the UART, held for the frame
//                  baud_set  [2:0]  baud code to the UART, latched at grant
//                master modport: requesters + transmitter side (drives inputs)
//                slave  modport: the arbiter itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xm_uart_tx_arb_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [2:0]  baud_cfg;
    logic        tx_done;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic        send_en;
    logic [7:0]  data_byte;
    logic [2:0]  baud_set;

    modport master (
        output req, req_data, baud_cfg, tx_done,
        input  gnt, done, err, busy, send_en, data_byte, baud_set
    );

    modport slave (
        input  req, req_data, baud_cfg, tx_done,
        output gnt, done, err, busy, send_en, data_byte, baud_set
    );
endinterface

`default_nettype wire

// File: rtl/xm_uart_tx_arb.sv
// ============================================================================
//  Module      : xm_uart_tx_arb
//  Description : Four-port round-robin arbiter and frame sequencer in front
//                of the xm_uart_tx transmitter. Picks one requester, latches
//                its byte and the baud code, pulses send_en, holds data_byte
//                stable for the whole frame, waits for tx_done and reports
//                done (or err on watchdog expiry) to the winner.
//  Ports       : clk  - system clock
//                rst  - asynchronous, active-low reset
//                bus  - xm_uart_tx_arb_if.slave (requests, grants,
//                       completions, transmitter handshake)
//  Parameters  : N_REQ   - number of requesters (fixed at 4, 2-bit pointer)
//                TIMEOUT - WAIT cycles allowed before abort
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xm_uart_tx_arb #(
    parameter int          N_REQ   = 4,
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  wire logic          clk,
    input  wire logic          rst,
    xm_uart_tx_arb_if.slave    bus
);

    localparam int c_PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [15:0]          r_wdog;

    logic [3:0]           r_gnt;
    logic [3:0]           r_done;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_send_en;
    logic [7:0]           r_data_byte;
    logic [2:0]           r_baud_set;

    logic [c_PTR_W-1:0]   w_idx;
    logic [c_PTR_W-1:0]   w_winner;
    logic                 w_found;

    // ------------------------------------------------------------------
    // Round-robin pick: first set request bit scanning ptr, ptr+1, ...
    // The pointer is exactly log2(N_REQ) bits wide, so the modulo wrap
    // falls out of the natural overflow of the addition.
    // ------------------------------------------------------------------
    always_comb begin
        w_idx    = r_ptr;
        w_winner = r_ptr;
        w_found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = r_ptr + c_PTR_W'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. Every output is a register; the pulses (gnt, send_en,
    // done, err) default low and are raised on the transition into the
    // state in which they must be visible.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_wdog      <= 16'd0;
            r_gnt       <= 4'd0;
            r_done      <= 4'd0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_send_en   <= 1'b0;
            r_data_byte <= 8'd0;
            r_baud_set  <= 3'd0;
        end else begin
            r_gnt     <= 4'd0;
            r_done    <= 4'd0;
            r_err     <= 1'b0;
            r_send_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // data_byte/baud_set only ever change here: the UART
                        // reads data_byte live for the whole frame.
                        r_owner     <= w_winner;
                        r_data_byte <= bus.req_data[{w_winner, 3'b000} +: 8];
                        r_baud_set  <= bus.baud_cfg;
                        r_gnt       <= 4'b0001 << w_winner;
                        r_send_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    // Clearing here makes the count 0 in the first WAIT cycle.
                    r_wdog  <= 16'd0;
                    r_ptr   <= r_owner + c_PTR_W'(1);
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // tx_done takes priority over a simultaneous expiry.
                    if (bus.tx_done) begin
                        r_done  <= 4'b0001 << r_owner;
                        r_state <= S_GAP;
                    end else if (r_wdog == TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_wdog  <= r_wdog + 16'd1;
                    end
                end

                S_GAP: begin
                    // One idle cycle so the UART can drop its busy flag
                    // before the next send_en.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.send_en   = r_send_en;
    assign bus.data_byte = r_data_byte;
    assign bus.baud_set  = r_baud_set;

endmodule

`default_nettype wire

// File: tb/tb_xm_uart_tx_arb.sv
// ============================================================================
//  Module      : tb_xm_uart_tx_arb
//  Description : Scoreboard bench for xm_uart_tx_arb. The stimulus process
//                plays requesters and transmitter, predicts every grant and
//                completion from the round-robin rules and pushes them into
//                queues; an independent monitor pops and compares whenever
//                the DUT pulses gnt/send_en/done/err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xm_uart_tx_arb;

    localparam logic [15:0] c_TIMEOUT = 16'd20;
    localparam int          c_TI      = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xm_uart_tx_arb_if bus();

    xm_uart_tx_arb #(
        .N_REQ   (4),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // stimulus-side copies of the DUT inputs
    logic [3:0]  req_v  = 4'd0;
    logic [31:0] data_v = 32'd0;
    logic [2:0]  baud_v = 3'd0;
    logic        txd    = 1'b0;

    assign bus.req      = req_v;
    assign bus.req_data = data_v;
    assign bus.baud_cfg = baud_v;
    assign bus.tx_done  = txd;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [7:0] data;
        logic [2:0] baud;
    } gnt_exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        bit         is_err;
    } cmp_exp_t;

    gnt_exp_t gq[$];
    cmp_exp_t cq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int mptr     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, mod 4.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-frame noise on everything a requester is free to change.
    task automatic scramble(input logic [3:0] protect);
        baud_v = 3'($urandom_range(0, 7));
        for (int i = 0; i < 4; i++)
            if (!protect[i] && ($urandom_range(0, 1) == 1))
                data_v[8*i +: 8] = 8'($urandom);
    endtask

    // One arbitration. Called in an IDLE cycle with req_v nonzero; the frame
    // completes d WAIT cycles in (tx_done at count d), or by timeout if
    // d exceeds the watchdog limit. Returns in the following IDLE cycle.
    task automatic round(input int d, input bit keep);
        int e, w, x;
        logic [3:0] m;
        e = cyc;
        w = rr_pick(req_v, mptr);
        if (w < 0) return;
        m = 4'(1 << w);
        x = (d <= c_TI) ? d : c_TI;
        gq.push_back('{e + 1, m, data_v[8*w +: 8], baud_v});
        cq.push_back('{e + 3 + x, m, (d > c_TI)});
        mptr = (w + 1) % 4;
        step();                                   // SEND
        if (keep) data_v[8*w +: 8] = 8'($urandom);
        else      req_v[w] = 1'b0;
        step();                                   // first WAIT, count 0
        for (int k = 0; k <= x; k++) begin
            if (k == d) txd = 1'b1;
            else        scramble(req_v);
            step();
            txd = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) txd = 1'b1; // stray tx_done in GAP
        step();                                   // IDLE
        txd = 1'b0;
    endtask

    // Grant requester 2, abort mid-WAIT with a one-cycle reset, then show a
    // stray tx_done is ignored and the pointer restarted at 0.
    task automatic reset_scenario();
        int e;
        req_v            = 4'b0100;
        data_v[23:16]    = 8'h3C;
        e                = cyc;
        gq.push_back('{e + 1, 4'b0100, 8'h3C, baud_v});
        step();                                   // SEND
        req_v = 4'd0;
        step();                                   // WAIT
        repeat (3) begin
            scramble(req_v);
            step();
        end
        rst  = 1'b0;
        mptr = 0;
        step();
        rst = 1'b1;                               // IDLE
        txd = 1'b1;
        step();
        txd = 1'b0;
        step();
        req_v = 4'b1010;                          // ptr 0 -> requester 1
        round(3, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    gnt_exp_t   g_cur;
    cmp_exp_t   c_cur;
    logic [7:0] hold_d   = 8'd0;
    logic [2:0] hold_b   = 3'd0;
    bit         in_frame = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs",
                  {bus.gnt, bus.done, bus.err, bus.busy, bus.send_en, bus.data_byte, bus.baud_set},
                  64'd0);
            hold_d   = 8'd0;
            hold_b   = 3'd0;
            in_frame = 1'b0;
        end else begin
            if ((bus.gnt != 4'd0) || bus.send_en) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", {bus.gnt, bus.send_en}, 64'd0);
                end else begin
                    g_cur = gq.pop_front();
                    check("gnt_cycle", cyc, g_cur.cyc);
                    check("gnt_mask", bus.gnt, g_cur.mask);
                    check("send_en", bus.send_en, 1);
                    hold_d   = g_cur.data;
                    hold_b   = g_cur.baud;
                    in_frame = 1'b1;
                end
            end
            check("data_byte", bus.data_byte, hold_d);
            check("baud_set", bus.baud_set, hold_b);
            check("busy", bus.busy, in_frame);
            if ((bus.done != 4'd0) || bus.err) begin
                check("gnt_overlap", bus.gnt, 0);
                if (cq.size() == 0) begin
                    check("unexpected_done_err", {bus.done, bus.err}, 64'd0);
                end else begin
                    c_cur = cq.pop_front();
                    check("cmp_cycle", cyc, c_cur.cyc);
                    check("done_mask", bus.done, c_cur.is_err ? 4'd0 : c_cur.mask);
                    check("err", bus.err, c_cur.is_err);
                end
                in_frame = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // all four requesting continuously: 0,1,2,3,0
        req_v  = 4'hF;
        data_v = $urandom;
        repeat (5) round($urandom_range(0, 10), 1'b1);
        req_v = 4'd0;
        step();

        // single request from requester 1
        req_v         = 4'b0010;
        data_v[15:8]  = 8'hA5;
        baud_v        = 3'd4;
        round(7, 1'b0);

        // pointer wrap 3 -> 0
        req_v = 4'b1000;
        round(2, 1'b0);
        req_v = 4'b1001;
        round(2, 1'b0);

        // watchdog expiry, then tx_done exactly at the limit, then immediate
        if (req_v == 4'd0) req_v = 4'b0001;
        round(c_TI + 5, 1'b0);
        if (req_v == 4'd0) req_v = 4'b0100;
        round(c_TI, 1'b0);
        if (req_v == 4'd0) req_v = 4'b0010;
        round(0, 1'b0);

        reset_scenario();

        // randomized traffic
        repeat (150) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_v[i] && ($urandom_range(0, 2) == 0)) begin
                    req_v[i]         = 1'b1;
                    data_v[8*i +: 8] = 8'($urandom);
                end
            end
            baud_v = 3'($urandom_range(0, 7));
            if (req_v == 4'd0) begin
                step();
            end else begin
                round($urandom_range(0, c_TI + 4), ($urandom_range(0, 3) == 0));
            end
        end

        req_v = 4'd0;
        repeat (5) step();
        check("gnt_queue_empty", gq.size(), 0);
        check("cmp_queue_empty", cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
